// File: rtl/alu_ctrl_seq_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_seq_pkg
//  Description : Shared opcode/funct constants, mult/div op encodings and
//                sequencer state encoding for the ID/EX ALU control block.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_ctrl_seq_pkg;

    // Opcodes
    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SW      = 6'h2B;

    // ALU funct codes
    localparam logic [5:0] FUNCT_NOP   = 6'h00;
    localparam logic [5:0] FUNCT_MULT  = 6'h18;
    localparam logic [5:0] FUNCT_MULTU = 6'h19;
    localparam logic [5:0] FUNCT_DIV   = 6'h1A;
    localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
    localparam logic [5:0] FUNCT_ADD   = 6'h20;
    localparam logic [5:0] FUNCT_ADDU  = 6'h21;
    localparam logic [5:0] FUNCT_AND   = 6'h24;
    localparam logic [5:0] FUNCT_OR    = 6'h25;
    localparam logic [5:0] FUNCT_XOR   = 6'h26;
    localparam logic [5:0] FUNCT_SLT   = 6'h2A;
    localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

    // Mult/div unit operation select (equals funct[1:0] of the instruction)
    localparam logic [1:0] MD_OP_MULT  = 2'd0;
    localparam logic [1:0] MD_OP_MULTU = 2'd1;
    localparam logic [1:0] MD_OP_DIV   = 2'd2;
    localparam logic [1:0] MD_OP_DIVU  = 2'd3;

    // Sequencer states
    typedef enum logic [0:0] {
        ST_IDLE    = 1'b0,
        ST_MD_BUSY = 1'b1
    } state_t;

endpackage : alu_ctrl_seq_pkg
`default_nettype wire

// File: rtl/alu_ctrl_seq_funct_decode.sv
`default_nettype none
// ============================================================================
//  Module      : alu_funct_decode
//  Description : Purely combinational opcode/funct -> ALU funct mapping, plus
//                a flag marking SPECIAL mult/div instructions.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_funct_decode
    import alu_ctrl_seq_pkg::*;
#(
    parameter int OP_WIDTH    = 6,
    parameter int FUNCT_WIDTH = 6
) (
    input  logic [OP_WIDTH-1:0]    op,
    input  logic [FUNCT_WIDTH-1:0] funct_in,
    output logic [FUNCT_WIDTH-1:0] funct_dec,
    output logic                   is_multdiv
);

    // Map opcode to ALU funct; SPECIAL passes the instruction funct through
    always_comb begin
        funct_dec = FUNCT_WIDTH'(FUNCT_NOP);
        case (op)
            OP_WIDTH'(OP_SPECIAL): funct_dec = funct_in;
            OP_WIDTH'(OP_LUI),
            OP_WIDTH'(OP_ORI),
            OP_WIDTH'(OP_JAL):     funct_dec = FUNCT_WIDTH'(FUNCT_OR);
            OP_WIDTH'(OP_LB),
            OP_WIDTH'(OP_LH),
            OP_WIDTH'(OP_LW),
            OP_WIDTH'(OP_LBU),
            OP_WIDTH'(OP_SB),
            OP_WIDTH'(OP_SW),
            OP_WIDTH'(OP_ADDIU):   funct_dec = FUNCT_WIDTH'(FUNCT_ADDU);
            OP_WIDTH'(OP_ADDI):    funct_dec = FUNCT_WIDTH'(FUNCT_ADD);
            OP_WIDTH'(OP_ANDI):    funct_dec = FUNCT_WIDTH'(FUNCT_AND);
            OP_WIDTH'(OP_XORI):    funct_dec = FUNCT_WIDTH'(FUNCT_XOR);
            OP_WIDTH'(OP_SLTI):    funct_dec = FUNCT_WIDTH'(FUNCT_SLT);
            OP_WIDTH'(OP_SLTIU):   funct_dec = FUNCT_WIDTH'(FUNCT_SLTU);
            default:               funct_dec = FUNCT_WIDTH'(FUNCT_NOP);
        endcase
    end

    // Flag MULT/MULTU/DIV/DIVU, which need the multi-cycle sequencer
    always_comb begin
        is_multdiv = 1'b0;
        if (op == OP_WIDTH'(OP_SPECIAL)) begin
            is_multdiv = (funct_in == FUNCT_WIDTH'(FUNCT_MULT))  ||
                         (funct_in == FUNCT_WIDTH'(FUNCT_MULTU)) ||
                         (funct_in == FUNCT_WIDTH'(FUNCT_DIV))   ||
                         (funct_in == FUNCT_WIDTH'(FUNCT_DIVU));
        end
    end

endmodule : alu_funct_decode
`default_nettype wire

// File: rtl/alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module      : alu_ctrl_seq
//  Description : ID/EX ALU control. Registers the decoded ALU funct into EX
//                and sequences multi-cycle mult/div ops (start pulse, stall
//                for N-1 cycles, abort on flush).
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_ctrl_seq
    import alu_ctrl_seq_pkg::*;
#(
    parameter int OP_WIDTH    = 6,
    parameter int FUNCT_WIDTH = 6,
    parameter int MUL_CYCLES  = 4,
    parameter int DIV_CYCLES  = 32,
    parameter int CNT_WIDTH   = $clog2((MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES) + 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   id_valid,
    input  logic [OP_WIDTH-1:0]    op,
    input  logic [FUNCT_WIDTH-1:0] funct_in,
    input  logic                   flush,
    output logic [FUNCT_WIDTH-1:0] funct_out,
    output logic                   funct_valid,
    output logic                   md_start,
    output logic [1:0]             md_op,
    output logic                   md_abort,
    output logic                   stall_req
);

    // Busy-counter load values: the accepting cycle is the first EX cycle,
    // so only N-1 further cycles are spent stalled.
    localparam logic [CNT_WIDTH-1:0] c_mul_load = CNT_WIDTH'(MUL_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_div_load = CNT_WIDTH'(DIV_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one  = CNT_WIDTH'(1);

    logic [FUNCT_WIDTH-1:0] w_funct_dec;
    logic                   w_is_multdiv;
    logic [CNT_WIDTH-1:0]   w_md_load;

    state_t                 r_state, w_state_nxt;
    logic [CNT_WIDTH-1:0]   r_cnt, w_cnt_nxt;
    logic [FUNCT_WIDTH-1:0] r_funct_out, w_funct_out_nxt;
    logic                   r_funct_valid, w_funct_valid_nxt;
    logic                   r_md_start, w_md_start_nxt;
    logic [1:0]             r_md_op, w_md_op_nxt;
    logic                   r_md_abort, w_md_abort_nxt;
    logic                   r_stall, w_stall_nxt;

    alu_funct_decode #(
        .OP_WIDTH    (OP_WIDTH),
        .FUNCT_WIDTH (FUNCT_WIDTH)
    ) u_decode (
        .op         (op),
        .funct_in   (funct_in),
        .funct_dec  (w_funct_dec),
        .is_multdiv (w_is_multdiv)
    );

    // funct bit 1 separates DIV/DIVU from MULT/MULTU
    assign w_md_load = funct_in[1] ? c_div_load : c_mul_load;

    // Next-state and next-output logic; pulses default low, held values hold
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_funct_out_nxt   = r_funct_out;
        w_funct_valid_nxt = 1'b0;
        w_md_start_nxt    = 1'b0;
        w_md_op_nxt       = r_md_op;
        w_md_abort_nxt    = 1'b0;
        w_stall_nxt       = r_stall;

        case (r_state)
            ST_IDLE: begin
                w_stall_nxt = 1'b0;
                if (!flush && id_valid) begin
                    w_funct_out_nxt   = w_funct_dec;
                    w_funct_valid_nxt = 1'b1;
                    if (w_is_multdiv) begin
                        w_md_start_nxt = 1'b1;
                        w_md_op_nxt    = funct_in[1:0];
                        w_cnt_nxt      = w_md_load;
                        // Single-cycle units never enter the busy state
                        if (w_md_load != '0) begin
                            w_state_nxt = ST_MD_BUSY;
                            w_stall_nxt = 1'b1;
                        end
                    end
                end
            end

            ST_MD_BUSY: begin
                if (flush) begin
                    w_md_abort_nxt = 1'b1;
                    w_cnt_nxt      = '0;
                    w_stall_nxt    = 1'b0;
                    w_state_nxt    = ST_IDLE;
                end else if (r_cnt <= c_cnt_one) begin
                    w_cnt_nxt   = '0;
                    w_stall_nxt = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_cnt_nxt   = r_cnt - c_cnt_one;
                    w_stall_nxt = 1'b1;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = '0;
                w_stall_nxt = 1'b0;
            end
        endcase
    end

    // State, counter and registered outputs; reset takes effect immediately
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_cnt         <= '0;
            r_funct_out   <= FUNCT_WIDTH'(FUNCT_NOP);
            r_funct_valid <= 1'b0;
            r_md_start    <= 1'b0;
            r_md_op       <= MD_OP_MULT;
            r_md_abort    <= 1'b0;
            r_stall       <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_cnt         <= w_cnt_nxt;
            r_funct_out   <= w_funct_out_nxt;
            r_funct_valid <= w_funct_valid_nxt;
            r_md_start    <= w_md_start_nxt;
            r_md_op       <= w_md_op_nxt;
            r_md_abort    <= w_md_abort_nxt;
            r_stall       <= w_stall_nxt;
        end
    end

    assign funct_out   = r_funct_out;
    assign funct_valid = r_funct_valid;
    assign md_start    = r_md_start;
    assign md_op       = r_md_op;
    assign md_abort    = r_md_abort;
    assign stall_req   = r_stall;

endmodule : alu_ctrl_seq
`default_nettype wire

// File: tb/tb_alu_ctrl_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_ctrl_seq
//  Description : Self-checking bench for alu_ctrl_seq. Default build (A) and
//                a MUL_CYCLES=1 build (B) share stimulus; each step names
//                which build its expectation applies to.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_ctrl_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       id_valid;
    logic [5:0] op;
    logic [5:0] funct_in;
    logic       flush;

    logic [5:0] a_funct_out, b_funct_out;
    logic       a_funct_valid, b_funct_valid;
    logic       a_md_start, b_md_start;
    logic [1:0] a_md_op, b_md_op;
    logic       a_md_abort, b_md_abort;
    logic       a_stall_req, b_stall_req;

    // Packed view: {funct_out, funct_valid, md_start, md_op, md_abort, stall_req}
    logic [11:0] act_a, act_b;
    assign act_a = {a_funct_out, a_funct_valid, a_md_start, a_md_op, a_md_abort, a_stall_req};
    assign act_b = {b_funct_out, b_funct_valid, b_md_start, b_md_op, b_md_abort, b_stall_req};

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    alu_ctrl_seq u_dut_a (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .op          (op),
        .funct_in    (funct_in),
        .flush       (flush),
        .funct_out   (a_funct_out),
        .funct_valid (a_funct_valid),
        .md_start    (a_md_start),
        .md_op       (a_md_op),
        .md_abort    (a_md_abort),
        .stall_req   (a_stall_req)
    );

    alu_ctrl_seq #(
        .MUL_CYCLES (1),
        .DIV_CYCLES (4)
    ) u_dut_b (
        .clk         (clk),
        .rst         (rst),
        .id_valid    (id_valid),
        .op          (op),
        .funct_in    (funct_in),
        .flush       (flush),
        .funct_out   (b_funct_out),
        .funct_valid (b_funct_valid),
        .md_start    (b_md_start),
        .md_op       (b_md_op),
        .md_abort    (b_md_abort),
        .stall_req   (b_stall_req)
    );

    typedef struct {
        string       name;
        bit          sel_b;
        logic        iv;
        logic [5:0]  op;
        logic [5:0]  fn;
        logic        fl;
        logic [11:0] exp;
    } vec_t;

    vec_t q_sb[$];
    vec_t tbl[$];

    function automatic vec_t mk(string n, bit sb, logic iv, logic [5:0] o, logic [5:0] f, logic fl,
                                logic [5:0] efo, logic efv, logic est, logic [1:0] emd,
                                logic eab, logic estl);
        vec_t v;
        v.name  = n;
        v.sel_b = sb;
        v.iv    = iv;
        v.op    = o;
        v.fn    = f;
        v.fl    = fl;
        v.exp   = {efo, efv, est, emd, eab, estl};
        return v;
    endfunction

    task automatic check(string name, logic [11:0] got, logic [11:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got fo=%h fv=%b start=%b md_op=%0d abort=%b stall=%b, expected fo=%h fv=%b start=%b md_op=%0d abort=%b stall=%b",
                     name, got[11:6], got[5], got[4], got[3:2], got[1], got[0],
                     exp[11:6], exp[5], exp[4], exp[3:2], exp[1], exp[0]);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge
    task automatic step(vec_t v);
        vec_t e;
        @(negedge clk);
        id_valid = v.iv;
        op       = v.op;
        funct_in = v.fn;
        flush    = v.fl;
        q_sb.push_back(v);
        @(posedge clk);
        #1;
        e = q_sb.pop_front();
        check(e.name, e.sel_b ? act_b : act_a, e.exp);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst      = 1'b1;
        id_valid = 1'b0;
        op       = 6'h00;
        funct_in = 6'h00;
        flush    = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Hard time bound so the bench always terminates
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Decode table on build A; funct_out holds across invalid/flushed cycles
        tbl.push_back(mk("ori",      0, 1, 6'h0D, 6'h00, 0, 6'h25, 1, 0, 2'd0, 0, 0));
        tbl.push_back(mk("xori",     0, 1, 6'h0E, 6'h00, 0, 6'h26, 1, 0, 2'd0, 0, 0));
        tbl.push_back(mk("lw",       0, 1, 6'h23, 6'h00, 0, 6'h21, 1, 0, 2'd0, 0, 0));
        tbl.push_back(mk("unknown",  0, 1, 6'h3F, 6'h00, 0, 6'h00, 1, 0, 2'd0, 0, 0));
        tbl.push_back(mk("slti",     0, 1, 6'h0A, 6'h00, 0, 6'h2A, 1, 0, 2'd0, 0, 0));
        tbl.push_back(mk("sltiu",    0, 1, 6'h0B, 6'h00, 0, 6'h2B, 1, 0, 2'd0, 0, 0));
        tbl.push_back(mk("addi",     0, 1, 6'h08, 6'h00, 0, 6'h20, 1, 0, 2'd0, 0, 0));
        tbl.push_back(mk("andi",     0, 1, 6'h0C, 6'h00, 0, 6'h24, 1, 0, 2'd0, 0, 0));
        tbl.push_back(mk("lui",      0, 1, 6'h0F, 6'h00, 0, 6'h25, 1, 0, 2'd0, 0, 0));
        tbl.push_back(mk("special",  0, 1, 6'h00, 6'h22, 0, 6'h22, 1, 0, 2'd0, 0, 0));
        tbl.push_back(mk("sb",       0, 1, 6'h28, 6'h00, 0, 6'h21, 1, 0, 2'd0, 0, 0));
        tbl.push_back(mk("jal",      0, 1, 6'h03, 6'h00, 0, 6'h25, 1, 0, 2'd0, 0, 0));
        tbl.push_back(mk("invalid",  0, 0, 6'h08, 6'h00, 0, 6'h25, 0, 0, 2'd0, 0, 0));
        tbl.push_back(mk("flush_id", 0, 1, 6'h0E, 6'h00, 1, 6'h25, 0, 0, 2'd0, 0, 0));
        tbl.push_back(mk("flush_md", 0, 1, 6'h00, 6'h18, 1, 6'h25, 0, 0, 2'd0, 0, 0));

        rst      = 1'b1;
        id_valid = 1'b0;
        op       = 6'h00;
        funct_in = 6'h00;
        flush    = 1'b0;
        #12;
        check("reset_a", act_a, 12'h000);
        check("reset_b", act_b, 12'h000);
        @(negedge clk);
        rst = 1'b0;

        foreach (tbl[i]) step(tbl[i]);

        // MULT: start pulse, 3 stall cycles, held ORI ignored then accepted
        step(mk("mult_start", 0, 1, 6'h00, 6'h18, 0, 6'h18, 1, 1, 2'd0, 0, 1));
        for (int i = 1; i <= 2; i++)
            step(mk($sformatf("mult_busy%0d", i), 0, 1, 6'h0D, 6'h00, 0, 6'h18, 0, 0, 2'd0, 0, 1));
        step(mk("mult_done",  0, 1, 6'h0D, 6'h00, 0, 6'h18, 0, 0, 2'd0, 0, 0));
        step(mk("mult_next",  0, 1, 6'h0D, 6'h00, 0, 6'h25, 1, 0, 2'd0, 0, 0));
        step(mk("mult_idle",  0, 0, 6'h0D, 6'h00, 0, 6'h25, 0, 0, 2'd0, 0, 0));

        // DIVU aborted by a flush on busy cycle 10
        step(mk("divu_start", 0, 1, 6'h00, 6'h1B, 0, 6'h1B, 1, 1, 2'd3, 0, 1));
        for (int i = 1; i <= 9; i++)
            step(mk($sformatf("divu_busy%0d", i), 0, 0, 6'h00, 6'h00, 0, 6'h1B, 0, 0, 2'd3, 0, 1));
        step(mk("divu_abort", 0, 0, 6'h00, 6'h00, 1, 6'h1B, 0, 0, 2'd3, 1, 0));
        for (int i = 1; i <= 3; i++)
            step(mk($sformatf("divu_post%0d", i), 0, 0, 6'h00, 6'h00, 0, 6'h1B, 0, 0, 2'd3, 0, 0));

        // DIV then ADDI held valid: ADDI lands one cycle after stall drops
        step(mk("div_start", 0, 1, 6'h00, 6'h1A, 0, 6'h1A, 1, 1, 2'd2, 0, 1));
        for (int i = 1; i <= 30; i++)
            step(mk($sformatf("div_busy%0d", i), 0, 1, 6'h08, 6'h00, 0, 6'h1A, 0, 0, 2'd2, 0, 1));
        step(mk("div_done",  0, 1, 6'h08, 6'h00, 0, 6'h1A, 0, 0, 2'd2, 0, 0));
        step(mk("div_addi",  0, 1, 6'h08, 6'h00, 0, 6'h20, 1, 0, 2'd2, 0, 0));
        step(mk("div_idle",  0, 0, 6'h08, 6'h00, 0, 6'h20, 0, 0, 2'd2, 0, 0));

        // Flush on the final busy cycle still aborts
        step(mk("mfin_start", 0, 1, 6'h00, 6'h18, 0, 6'h18, 1, 1, 2'd0, 0, 1));
        for (int i = 1; i <= 2; i++)
            step(mk($sformatf("mfin_busy%0d", i), 0, 0, 6'h00, 6'h00, 0, 6'h18, 0, 0, 2'd0, 0, 1));
        step(mk("mfin_abort", 0, 0, 6'h00, 6'h00, 1, 6'h18, 0, 0, 2'd0, 1, 0));
        step(mk("mfin_idle",  0, 0, 6'h00, 6'h00, 0, 6'h18, 0, 0, 2'd0, 0, 0));

        // Asynchronous reset in the middle of a DIV busy period
        step(mk("ar_start", 0, 1, 6'h00, 6'h1A, 0, 6'h1A, 1, 1, 2'd2, 0, 1));
        for (int i = 1; i <= 4; i++)
            step(mk($sformatf("ar_busy%0d", i), 0, 0, 6'h00, 6'h00, 0, 6'h1A, 0, 0, 2'd2, 0, 1));
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("ar_immediate", act_a, 12'h000);
        @(posedge clk);
        #1;
        check("ar_held", act_a, 12'h000);
        @(negedge clk);
        rst = 1'b0;
        step(mk("ar_after",   0, 0, 6'h00, 6'h00, 0, 6'h00, 0, 0, 2'd0, 0, 0));
        step(mk("ar_accept",  0, 1, 6'h0D, 6'h00, 0, 6'h25, 1, 0, 2'd0, 0, 0));

        // Build B: single-cycle multiply never stalls
        do_reset();
        step(mk("b_multu",   1, 1, 6'h00, 6'h19, 0, 6'h19, 1, 1, 2'd1, 0, 0));
        step(mk("b_next",    1, 1, 6'h0D, 6'h00, 0, 6'h25, 1, 0, 2'd1, 0, 0));
        step(mk("b_div",     1, 1, 6'h00, 6'h1A, 0, 6'h1A, 1, 1, 2'd2, 0, 1));
        for (int i = 1; i <= 2; i++)
            step(mk($sformatf("b_div_busy%0d", i), 1, 0, 6'h00, 6'h00, 0, 6'h1A, 0, 0, 2'd2, 0, 1));
        step(mk("b_div_done", 1, 0, 6'h00, 6'h00, 0, 6'h1A, 0, 0, 2'd2, 0, 0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_alu_ctrl_seq
`default_nettype wire

// File: doc/alu_ctrl_seq.md
Name: alu_ctrl_seq

Overview:
- Next-generation ALU control for the ID/EX boundary.
- Decodes op/funct into the ALU funct code and registers it into EX with one cycle of latency.
- Sequences multi-cycle multiply/divide: issues a start pulse to the mult/div unit and holds a pipeline stall for a parametrised number of cycles.
- Supports flush/abort and extends immediate-op coverage (XORI, SLTI, SLTIU).

Parameters:
- OP_WIDTH, 6, opcode field width
- FUNCT_WIDTH, 6, funct field width
- MUL_CYCLES, 4, total EX cycles for MULT/MULTU (>=1)
- DIV_CYCLES, 32, total EX cycles for DIV/DIVU (>=1)
- CNT_WIDTH, $clog2(max(MUL_CYCLES, DIV_CYCLES))+1, busy-counter width

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- id_valid  in  1  ID holds a valid instruction
- op  in  OP_WIDTH  instruction opcode
- funct_in  in  FUNCT_WIDTH  instruction funct field
- flush  in  1  pipeline flush (branch/exception)
- funct_out  out  FUNCT_WIDTH  registered ALU funct to EX
- funct_valid  out  1  funct_out is valid this cycle
- md_start  out  1  one-cycle start pulse to mult/div unit
- md_op  out  2  0=MULT 1=MULTU 2=DIV 3=DIVU, valid with md_start
- md_abort  out  1  one-cycle abort pulse to mult/div unit
- stall_req  out  1  hold IF/ID while a mult/div is in flight

Behaviour:
- Reset (async, rst=1): funct_out=FUNCT_NOP (0x00); funct_valid, md_start, md_abort, stall_req=0; md_op=0; counter=0; state=IDLE.
- Decode (combinational, internal):
  - SPECIAL(0x00) -> funct_in
  - LUI(0x0F), ORI(0x0D), JAL(0x03) -> OR(0x25)
  - LB(0x20), LH(0x21), LW(0x23), LBU(0x24), SB(0x28), SW(0x2B), ADDIU(0x09) -> ADDU(0x21)
  - ADDI(0x08) -> ADD(0x20)
  - ANDI(0x0C) -> AND(0x24)
  - XORI(0x0E) -> XOR(0x26)
  - SLTI(0x0A) -> SLT(0x2A)
  - SLTIU(0x0B) -> SLTU(0x2B)
  - all other opcodes -> NOP(0x00)
- Multi-cycle op = SPECIAL with funct 0x18..0x1B.
- States: IDLE, MD_BUSY.
- IDLE, id_valid=1, flush=0:
  - Next edge: funct_out=decoded funct, funct_valid=1.
  - If multi-cycle op: md_start=1 and md_op=funct_in[1:0] for that single cycle; counter loaded with N-1 (N=MUL_CYCLES or DIV_CYCLES).
  - If N-1>0, go to MD_BUSY; otherwise stay IDLE with no stall.
- IDLE, id_valid=0: funct_valid=0 next cycle; funct_out holds its last value.
- MD_BUSY:
  - stall_req=1 (registered, asserted from the cycle after md_start).
  - Counter decrements each cycle; funct_valid=0; id_valid ignored.
  - Counter==1: decrement to 0 and return to IDLE; stall_req=0 on the following cycle.
  - Total stall cycles = N-1.
- flush has priority over everything:
  - In IDLE: the instruction is not accepted; funct_valid=0 and md_start=0 next cycle.
  - In MD_BUSY: md_abort=1 for one cycle, counter cleared, stall_req=0, state=IDLE next cycle.
- flush coincident with the final busy cycle: abort still pulses.
- md_start and md_abort are never high in the same cycle.
- Reset mid-MD_BUSY: immediate return to reset values; no abort pulse.
- Back-to-back mult/div: the second op is accepted in the first IDLE cycle after the busy period (upstream holds it via stall_req).

Decomposition:
- Shared package/header: OP_* and FUNCT_* constants (add OP_XORI, OP_SLTI, OP_SLTIU, FUNCT_SLT, FUNCT_SLTU, FUNCT_MULT..DIVU), MD_OP encodings, state encodings.
- One natural sub-module, alu_funct_decode: purely combinational opcode -> funct mapping plus the is_multdiv flag. The sequencer wraps it.

Test Plan:
- Reset, then op=ORI(0x0D), id_valid=1 -> next cycle funct_out=0x25, funct_valid=1; XORI -> 0x26; LW -> 0x21; unknown op 0x3F -> 0x00.
- SPECIAL with funct_in=0x18, MUL_CYCLES=4 -> md_start=1 with md_op=0 for 1 cycle; stall_req=1 for exactly 3 cycles; id_valid ignored during the stall.
- DIVU (funct 0x1B), DIV_CYCLES=32, flush asserted on busy cycle 10 -> md_abort=1 for one cycle, stall_req=0 and IDLE on the next cycle, no further funct_valid.
- MUL_CYCLES=1 build, MULTU -> md_start pulse, md_op=1, stall_req never asserted, next instruction accepted on the following cycle.
- DIV followed immediately by ADDI held valid -> ADDI funct_out=0x20 with funct_valid=1 one cycle after stall_req drops.
- rst pulsed asynchronously (mid-cycle) during MD_BUSY -> all outputs return to reset values immediately, no md_abort pulse.
